// File: rtl/apb_wait_slave_if.sv
// APB3 bus bundle between a bridge and a single slave.
// The bridge drives the request side; the slave answers with data, ready and error.
interface apb_wait_slave_if #(
    parameter int unsigned ADDRWIDTH = 12
);
    logic                 psel;
    logic                 penable;
    logic                 pwrite;
    logic [ADDRWIDTH-1:0] paddr;
    logic [31:0]          pwdata;
    logic [31:0]          prdata;
    logic                 pready;
    logic                 pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_wait_slave.sv
// APB3 register slave: 16-word RAM, a programmable wait-state count,
// a constant ID word and a saturating error counter.
module apb_wait_slave #(
    parameter int unsigned ADDRWIDTH = 12,
    parameter logic [31:0] ID_VALUE  = 32'h5A5A_0001,
    parameter logic [3:0]  WAIT_RST  = 4'd0
) (
    input logic              clk,
    input logic              rst,
    apb_wait_slave_if.slave  apb
);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [3:0]  wait_lat;
    logic [3:0]  wait_cfg;
    logic [15:0] err_cnt;
    logic [31:0] mem [16];

    logic        in_access;
    logic        ready_int;
    logic        addr_err;
    logic        err_int;
    logic        wr_commit;
    logic        sel_mem;
    logic        sel_wait;
    logic        sel_id;
    logic        sel_status;
    logic [31:0] rd_mux;

    // Address decode
    always_comb begin
        sel_mem    = (apb.paddr <  ADDRWIDTH'('h040));
        sel_wait   = (apb.paddr == ADDRWIDTH'('h040));
        sel_id     = (apb.paddr == ADDRWIDTH'('h044));
        sel_status = (apb.paddr == ADDRWIDTH'('h048));
        addr_err   = (apb.paddr[1:0] != 2'b00)
                   || (apb.paddr >= ADDRWIDTH'('h04C))
                   || (apb.pwrite && (sel_id || sel_status));
    end

    // pready is decoded from registered state so the wait count is exact.
    always_comb begin
        in_access = (state == ACCESS) && apb.psel && apb.penable;
        ready_int = in_access && (cnt == wait_lat);
        err_int   = ready_int && addr_err;
        wr_commit = ready_int && apb.pwrite && !addr_err;
    end

    always_comb begin
        rd_mux = '0;
        if (sel_mem)
            rd_mux = mem[apb.paddr[5:2]];
        else if (sel_wait)
            rd_mux = {28'h0, wait_cfg};
        else if (sel_id)
            rd_mux = ID_VALUE;
        else if (sel_status)
            rd_mux = {16'h0, err_cnt};
    end

    always_comb begin
        apb.pready  = ready_int;
        apb.pslverr = err_int;
        apb.prdata  = (ready_int && !apb.pwrite && !addr_err) ? rd_mux : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            wait_lat <= '0;
            wait_cfg <= WAIT_RST;
            err_cnt  <= '0;
            for (int unsigned i = 0; i < 16; i++)
                mem[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (apb.psel && !apb.penable) begin
                        state    <= ACCESS;
                        wait_lat <= wait_cfg;
                        cnt      <= '0;
                    end
                end
                ACCESS: begin
                    // A dropped psel aborts the transfer; nothing commits.
                    if (!apb.psel || ready_int) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (apb.penable) begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (wr_commit) begin
                if (sel_mem)
                    mem[apb.paddr[5:2]] <= apb.pwdata;
                else if (sel_wait)
                    wait_cfg <= apb.pwdata[3:0];
            end

            if (err_int && (err_cnt != '1))
                err_cnt <= err_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_apb_wait_slave.sv
// Directed bench for apb_wait_slave: latency, register map, errors,
// aborted transfers, reset mid-transfer and error-counter saturation.
module tb_apb_wait_slave;

    localparam logic [31:0] ID_VAL = 32'h5A5A_0001;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    apb_wait_slave_if #(.ADDRWIDTH(12)) bus ();

    apb_wait_slave #(
        .ADDRWIDTH (12),
        .ID_VALUE  (ID_VAL),
        .WAIT_RST  (4'd0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .apb (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Full transfer: setup, then access cycles until pready (bounded).
    task automatic apb_xfer(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err, output int cycles);
        logic done;
        @(negedge clk);
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = wr;
        bus.paddr   = addr;
        bus.pwdata  = wdata;
        #1 check("setup_pready", 32'(bus.pready), 32'd0);
        @(negedge clk);
        bus.penable = 1'b1;
        cycles = 0;
        rdata  = '0;
        err    = 1'b0;
        done   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1 cycles++;
            if (bus.pready) begin
                rdata = bus.prdata;
                err   = bus.pslverr;
                done  = 1'b1;
                break;
            end
            check("wait_pslverr", 32'(bus.pslverr), 32'd0);
            @(negedge clk);
        end
        check("xfer_done", 32'(done), 32'd1);
    endtask

    // Setup plus n access cycles, leaving the transfer open.
    task automatic apb_partial(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                               input int n);
        @(negedge clk);
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = wr;
        bus.paddr   = addr;
        bus.pwdata  = wdata;
        @(negedge clk);
        bus.penable = 1'b1;
        for (int i = 1; i < n; i++)
            @(negedge clk);
    endtask

    task automatic bus_idle();
        @(negedge clk);
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          cy;

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        rst         = 1'b1;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        bus.paddr   = '0;
        bus.pwdata  = '0;

        #12;
        check("rst_pready",  32'(bus.pready),  32'd0);
        check("rst_pslverr", 32'(bus.pslverr), 32'd0);
        check("rst_prdata",  bus.prdata,       32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Zero-wait write then read
        apb_xfer(1'b1, 12'h008, 32'hDEADBEEF, rd, er, cy);
        check("zw_wr_cycles", 32'(cy), 32'd1);
        check("zw_wr_err",    32'(er), 32'd0);
        check("zw_wr_prdata", rd,      32'd0);
        apb_xfer(1'b0, 12'h008, 32'h0, rd, er, cy);
        check("zw_rd_cycles", 32'(cy), 32'd1);
        check("zw_rd_data",   rd,      32'hDEADBEEF);
        check("zw_rd_err",    32'(er), 32'd0);

        // Three wait states
        apb_xfer(1'b1, 12'h040, 32'hFFFF_FFF3, rd, er, cy);
        check("wcfg3_wr_cycles", 32'(cy), 32'd1);
        apb_xfer(1'b0, 12'h044, 32'h0, rd, er, cy);
        check("id_cycles", 32'(cy), 32'd4);
        check("id_data",   rd,      ID_VAL);
        check("id_err",    32'(er), 32'd0);
        apb_xfer(1'b0, 12'h040, 32'h0, rd, er, cy);
        check("wcfg_rd_data", rd, 32'd3);

        // Error cases
        apb_xfer(1'b1, 12'h044, 32'h12345678, rd, er, cy);
        check("wr_id_err",    32'(er), 32'd1);
        check("wr_id_cycles", 32'(cy), 32'd4);
        apb_xfer(1'b0, 12'h050, 32'h0, rd, er, cy);
        check("rd_050_err",  32'(er), 32'd1);
        check("rd_050_data", rd,      32'd0);
        apb_xfer(1'b0, 12'h006, 32'h0, rd, er, cy);
        check("rd_006_err",  32'(er), 32'd1);
        check("rd_006_data", rd,      32'd0);
        apb_xfer(1'b0, 12'h044, 32'h0, rd, er, cy);
        check("id_unchanged", rd, ID_VAL);
        apb_xfer(1'b0, 12'h048, 32'h0, rd, er, cy);
        check("status_3",     rd,      32'h0000_0003);
        check("status_3_err", 32'(er), 32'd0);

        // Mid-transfer WAIT_CFG write uses the latched value
        apb_xfer(1'b1, 12'h040, 32'd2, rd, er, cy);
        check("wcfg2_cycles", 32'(cy), 32'd4);
        apb_xfer(1'b1, 12'h040, 32'd0, rd, er, cy);
        check("wcfg0_cycles", 32'(cy), 32'd3);
        apb_xfer(1'b0, 12'h040, 32'h0, rd, er, cy);
        check("after_wcfg0_cycles", 32'(cy), 32'd1);
        check("after_wcfg0_data",   rd,      32'd0);

        // Map boundaries
        apb_xfer(1'b1, 12'h03C, 32'hA5A5_5A5A, rd, er, cy);
        apb_xfer(1'b0, 12'h03C, 32'h0, rd, er, cy);
        check("mem15_data", rd,      32'hA5A5_5A5A);
        check("mem15_err",  32'(er), 32'd0);
        apb_xfer(1'b0, 12'h04C, 32'h0, rd, er, cy);
        check("rd_04c_err", 32'(er), 32'd1);
        apb_xfer(1'b1, 12'h000, 32'h1111_1111, rd, er, cy);
        apb_xfer(1'b0, 12'h000, 32'h0, rd, er, cy);
        check("mem0_data", rd, 32'h1111_1111);

        // psel dropped during access: no write, no error count
        apb_xfer(1'b1, 12'h040, 32'd2, rd, er, cy);
        apb_partial(1'b1, 12'h004, 32'hCAFE_F00D, 1);
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        #1 check("abort_pready", 32'(bus.pready), 32'd0);
        apb_xfer(1'b0, 12'h004, 32'h0, rd, er, cy);
        check("abort_no_write", rd,      32'd0);
        check("abort_cycles",   32'(cy), 32'd3);
        apb_xfer(1'b0, 12'h048, 32'h0, rd, er, cy);
        check("abort_status", rd, 32'h0000_0004);

        // Reset in the third access cycle of a 5-wait write
        apb_xfer(1'b1, 12'h040, 32'd5, rd, er, cy);
        apb_partial(1'b1, 12'h000, 32'h5555_5555, 3);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_pready",  32'(bus.pready),  32'd0);
        check("mid_rst_pslverr", 32'(bus.pslverr), 32'd0);
        check("mid_rst_prdata",  bus.prdata,       32'd0);
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        apb_xfer(1'b0, 12'h000, 32'h0, rd, er, cy);
        check("post_rst_mem0",   rd,      32'd0);
        check("post_rst_cycles", 32'(cy), 32'd1);
        apb_xfer(1'b0, 12'h040, 32'h0, rd, er, cy);
        check("post_rst_wcfg", rd, 32'd0);
        apb_xfer(1'b0, 12'h048, 32'h0, rd, er, cy);
        check("post_rst_status", rd, 32'd0);
        bus_idle();

        // Error counter saturation from a preset count of 0xFFFE
        @(negedge clk);
        force dut.err_cnt = 16'hFFFE;
        #1 release dut.err_cnt;
        apb_xfer(1'b0, 12'h001, 32'h0, rd, er, cy);
        check("sat_err1", 32'(er), 32'd1);
        apb_xfer(1'b0, 12'h048, 32'h0, rd, er, cy);
        check("sat_status_ffff", rd, 32'h0000_FFFF);
        apb_xfer(1'b1, 12'h048, 32'h0, rd, er, cy);
        apb_xfer(1'b0, 12'h100, 32'h0, rd, er, cy);
        check("sat_err3", 32'(er), 32'd1);
        apb_xfer(1'b0, 12'h048, 32'h0, rd, er, cy);
        check("sat_status_hold", rd, 32'h0000_FFFF);
        bus_idle();
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/apb_wait_slave.md
APB_WAIT_SLAVE -- requirements
Module: apb_wait_slave

Interface
REQ-001 Parameter ADDRWIDTH, default 12, width of paddr.
REQ-002 Parameter ID_VALUE, default 32'h5A5A_0001, constant returned by ID register.
REQ-003 Parameter WAIT_RST, default 4'd0, reset value of WAIT_CFG.
REQ-004 Port clk  input  1  clock (same clock as the bridge's clk/HCLK domain); one clock only.
REQ-005 Port rst  input  1  reset, asynchronous, active-high; one clock, reset asynchronous and active-high.
REQ-006 Port psel  input  1  slave select from bridge.
REQ-007 Port penable  input  1  APB access phase indicator.
REQ-008 Port pwrite  input  1  1 = write, 0 = read.
REQ-009 Port paddr  input  ADDRWIDTH  byte address.
REQ-010 Port pwdata  input  32  write data.
REQ-011 Port prdata  output  32  read data.
REQ-012 Port pready  output  1  transfer completion (APB3).
REQ-013 Port pslverr  output  1  transfer error (APB3).

Function
REQ-014 Register map (word addresses): 0x000-0x03C MEM[0..15] RW 32b; 0x040 WAIT_CFG RW bits[3:0], bits[31:4] read 0; 0x044 ID RO = ID_VALUE; 0x048 STATUS RO, [15:0] error count, [31:16] = 0.
REQ-015 FSM states IDLE, ACCESS; IDLE->ACCESS when psel=1 & penable=0 (setup phase); ACCESS->IDLE on cycle with pready=1 or psel=0.
REQ-016 On IDLE->ACCESS transition, WAIT_CFG shall be latched into wait_lat and 4-bit cycle counter cnt cleared to 0.
REQ-017 In ACCESS with psel=1 & penable=1, cnt increments each cycle pready=0; pready = (state==ACCESS) & psel & penable & (cnt==wait_lat), combinational from registered state.
REQ-018 Latency: with wait_lat=N, pready asserts in the (N+1)th access-phase cycle; N=0 gives zero-wait APB transfer; N=15 gives 16 access cycles.
REQ-019 pready shall be 0 in IDLE and in setup phase.
REQ-020 Error condition: paddr[1:0]!=0, or paddr>=0x04C, or write to 0x044/0x048.
REQ-021 pslverr = pready & error condition; pslverr shall be 0 whenever pready=0.
REQ-022 Write commits only in the cycle psel & penable & pready & pwrite & !error; errored writes change no register.
REQ-023 Write to WAIT_CFG mid-transfer affects only subsequent transfers (latched copy used for current one).
REQ-024 prdata = selected register value in cycle pready=1 & !pwrite & !error; 32'h0 otherwise (including errored reads).
REQ-025 STATUS error count increments by 1 in each cycle pslverr=1, saturating at 16'hFFFF (no wrap).
REQ-026 psel dropped while in ACCESS before pready (protocol violation): return to IDLE, no write, no error count, cnt cleared.
REQ-027 Back-to-back transfers: setup phase in cycle after completion shall start a new transfer with fresh WAIT_CFG latch.

Reset
REQ-028 While rst=1: state=IDLE, cnt=0, wait_lat=0, MEM[0..15]=0, WAIT_CFG=WAIT_RST, STATUS=0; prdata=0, pready=0, pslverr=0 asynchronously.
REQ-029 rst asserted mid-transfer aborts it; no pending write commits; first transfer after deassertion shall follow REQ-015.

Verification
REQ-030 Zero-wait write 0xDEADBEEF to 0x008 then read 0x008 -> pready in first access cycle each; prdata=0xDEADBEEF, pslverr=0.
REQ-031 Write WAIT_CFG=3, then read 0x044 -> read access phase lasts 4 cycles, pready only in 4th, prdata=ID_VALUE.
REQ-032 Write 0x12345678 to 0x044, read 0x050, read 0x006 -> pslverr=1 on each completion, ID unchanged, STATUS reads 0x00000003.
REQ-033 WAIT_CFG=2, transfer in progress writes WAIT_CFG=0 -> current transfer completes after 3 access cycles, next transfer zero-wait.
REQ-034 WAIT_CFG=5, assert rst in 3rd access cycle of write to 0x000 -> outputs 0 immediately, MEM[0]=0, WAIT_CFG=WAIT_RST after release.
REQ-035 Force STATUS count to 0xFFFE via errored transfers, issue 3 more errors -> STATUS reads 0x0000FFFF.
